// File: rtl/key_pkg.sv
// Shared constants and repeat-state encoding for the pushbutton conditioner.
package key_pkg;

  localparam int KC_DEBOUNCE_DEF = 4;
  localparam int KC_CNT_W_DEF    = 16;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    HELD      = 2'd1,
    REPEATING = 2'd2
  } rep_state_e;

endpackage

// File: rtl/key_conditioner_if.sv
// Key vector bundle between the board pins and the core.
interface key_conditioner_if #(
  parameter int N_KEYS = 2
);
  logic [N_KEYS-1:0] key_n_in;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic              any_active;

  modport master (
    output key_n_in,
    input  key_level, key_press, key_release, any_active
  );

  modport slave (
    input  key_n_in,
    output key_level, key_press, key_release, any_active
  );
endinterface

// File: rtl/key_channel.sv
// One key: two-flop synchroniser, debounce counter, auto-repeat FSM, registered pulses.
//   state     | meaning
//   RELEASED  | debounced level low, no repeat timing
//   HELD      | accepted press, counting toward first repeat
//   REPEATING | emitting a press pulse every REPEAT_PERIOD cycles
module key_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KC_DEBOUNCE_DEF,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 8,
  parameter int CNT_W           = KC_CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1_q, s2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  rep_state_e       state_q, state_d;
  logic             sample;
  logic             accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      dcnt_q    <= '0;
      rcnt_q    <= '0;
      state_q   <= RELEASED;
    end else begin
      s1_q      <= key_n_i;
      s2_q      <= s1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      dcnt_q    <= dcnt_d;
      rcnt_q    <= rcnt_d;
      state_q   <= state_d;
    end
  end

  always_comb begin
    sample    = ~s2_q;
    accept    = 1'b0;
    level_d   = level_q;
    dcnt_d    = dcnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    rcnt_d    = rcnt_q;
    state_d   = state_q;

    if (sample == level_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DEB_LAST) begin
      accept  = 1'b1;
      level_d = sample;
      dcnt_d  = '0;
    end else if (dcnt_q != CNT_MAX) begin
      dcnt_d = dcnt_q + CNT_ONE;
    end

    press_d   = accept & sample;
    release_d = accept & ~sample;

    unique case (state_q)
      RELEASED: begin
        rcnt_d = '0;
        if (accept && sample) state_d = HELD;
      end
      HELD, REPEATING: begin
        // An accepted release wins over a repeat tick landing on the same edge.
        if (accept && !sample) begin
          state_d = RELEASED;
          rcnt_d  = '0;
        end else if (REPEAT_DELAY != 0) begin
          if (rcnt_q == ((state_q == HELD) ? DLY_LAST : PER_LAST)) begin
            press_d = 1'b1;
            state_d = REPEATING;
            rcnt_d  = '0;
          end else if (rcnt_q != CNT_MAX) begin
            rcnt_d = rcnt_q + CNT_ONE;
          end
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/key_conditioner.sv
// Pushbutton front end: N_KEYS independent conditioned channels plus an any-key flag.
module key_conditioner
  import key_pkg::*;
#(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = KC_DEBOUNCE_DEF,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 8,
  parameter int CNT_W           = KC_CNT_W_DEF
) (
  input logic               clk,
  input logic               rst,
  key_conditioner_if.slave  kif
);

  logic [N_KEYS-1:0] level;
  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] rel;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .key_n_i   (kif.key_n_in[i]),
      .level_o   (level[i]),
      .press_o   (press[i]),
      .release_o (rel[i])
    );
  end

  assign kif.key_level   = level;
  assign kif.key_press   = press;
  assign kif.key_release = rel;
  assign kif.any_active  = |level;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE=4, REPEAT_DELAY=6, REPEAT_PERIOD=3.
module tb_key_conditioner;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  key_conditioner_if #(.N_KEYS(2)) kif ();

  key_conditioner #(
    .N_KEYS          (2),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (6),
    .REPEAT_PERIOD   (3),
    .CNT_W           (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] key_n;
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rel;
  } vec_t;

  vec_t vec [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [1:0] lvl,
                     input logic [1:0] prs, input logic [1:0] rel);
    total++;
    if (kif.key_level !== lvl || kif.key_press !== prs ||
        kif.key_release !== rel || kif.any_active !== (|lvl)) begin
      bad++;
      $display("FAIL %s t=%0t: got level=%b press=%b release=%b any=%b, want level=%b press=%b release=%b any=%b",
               name, $time, kif.key_level, kif.key_press, kif.key_release,
               kif.any_active, lvl, prs, rel, |lvl);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ep, el, er;

    // key0 press accepted at edge 5, raw released before edge 6 -> falls at edge 11,
    // which is also the first repeat slot: only the release pulse may appear.
    vec[0]  = '{2'b10, 2'b00, 2'b00, 2'b00};
    vec[1]  = '{2'b10, 2'b00, 2'b00, 2'b00};
    vec[2]  = '{2'b10, 2'b00, 2'b00, 2'b00};
    vec[3]  = '{2'b10, 2'b00, 2'b00, 2'b00};
    vec[4]  = '{2'b10, 2'b00, 2'b00, 2'b00};
    vec[5]  = '{2'b10, 2'b01, 2'b01, 2'b00};
    vec[6]  = '{2'b11, 2'b01, 2'b00, 2'b00};
    vec[7]  = '{2'b11, 2'b01, 2'b00, 2'b00};
    vec[8]  = '{2'b11, 2'b01, 2'b00, 2'b00};
    vec[9]  = '{2'b11, 2'b01, 2'b00, 2'b00};
    vec[10] = '{2'b11, 2'b01, 2'b00, 2'b00};
    vec[11] = '{2'b11, 2'b00, 2'b00, 2'b01};
    vec[12] = '{2'b11, 2'b00, 2'b00, 2'b00};
    vec[13] = '{2'b11, 2'b00, 2'b00, 2'b00};

    // Reset held with both keys pressed.
    rst = 1'b1;
    kif.key_n_in = 2'b00;
    repeat (10) @(posedge clk);
    #1 chk("rst_hold", 2'b00, 2'b00, 2'b00);
    @(negedge clk) rst = 1'b0;
    for (int e = 0; e < 5; e++) begin
      tick();
      chk($sformatf("rst_quiet_e%0d", e), 2'b00, 2'b00, 2'b00);
    end
    tick();
    chk("rst_accept_e5", 2'b11, 2'b11, 2'b00);
    kif.key_n_in = 2'b11;
    tick();
    chk("rst_accept_e6", 2'b11, 2'b00, 2'b00);
    repeat (4) tick();
    tick();
    chk("rst_release_e11", 2'b00, 2'b00, 2'b11);
    tick();
    chk("rst_idle", 2'b00, 2'b00, 2'b00);

    // Clean press/release table.
    for (int j = 0; j < 14; j++) begin
      kif.key_n_in = vec[j].key_n;
      tick();
      chk($sformatf("vec%0d", j), vec[j].lvl, vec[j].prs, vec[j].rel);
    end

    // Bounce: 3 low, 1 high, five times.
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        kif.key_n_in = (c < 3) ? 2'b10 : 2'b11;
        tick();
        chk($sformatf("bounce_r%0d_c%0d", r, c), 2'b00, 2'b00, 2'b00);
      end
    end
    kif.key_n_in = 2'b11;
    repeat (3) begin
      tick();
      chk("bounce_tail", 2'b00, 2'b00, 2'b00);
    end

    // Auto-repeat on key1: accept at edge 5, repeats at 11,14,17,20,23;
    // raw released before edge 21 -> accepted release at 26, a repeat slot.
    for (int e = 0; e < 29; e++) begin
      kif.key_n_in = (e < 21) ? 2'b01 : 2'b11;
      tick();
      el = (e >= 5 && e < 26) ? 2'b10 : 2'b00;
      ep = (e == 5 || e == 11 || e == 14 || e == 17 || e == 20 || e == 23) ? 2'b10 : 2'b00;
      er = (e == 26) ? 2'b10 : 2'b00;
      chk($sformatf("repeat_e%0d", e), el, ep, er);
    end

    // Reset while key0 is repeating and its release debounce is in progress.
    for (int e = 0; e < 17; e++) begin
      kif.key_n_in = (e < 14) ? 2'b10 : 2'b11;
      tick();
    end
    chk("mid_pre_rst", 2'b01, 2'b00, 2'b00);
    #2 rst = 1'b1;
    #1 chk("mid_rst_async", 2'b00, 2'b00, 2'b00);
    kif.key_n_in = 2'b10;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int e = 0; e < 5; e++) begin
      tick();
      chk($sformatf("mid_quiet_e%0d", e), 2'b00, 2'b00, 2'b00);
    end
    tick();
    chk("mid_accept_e5", 2'b01, 2'b01, 2'b00);
    kif.key_n_in = 2'b11;
    repeat (5) tick();
    tick();
    chk("mid_release_e11", 2'b00, 2'b00, 2'b01);
    tick();
    chk("mid_idle", 2'b00, 2'b00, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
